// File: rtl/alu_exec_unit_rv32i_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the RV32I execution unit and its decoder:
//   XLEN_DEFAULT : default operand/result width
//   alu_op_t     : 4-bit ALU operation code produced by the decoder
//   md_state_t   : state encoding of the iterative mul/div sequencer
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_XOR   = 4'd2,
      OP_OR    = 4'd3,
      OP_AND   = 4'd4,
      OP_SLL   = 4'd5,
      OP_SRL   = 4'd6,
      OP_SRA   = 4'd7,
      OP_SLT   = 4'd8,
      OP_SLTU  = 4'd9,
      OP_RSVD  = 4'd10,
      OP_PASSB = 4'd11,
      OP_ABS   = 4'd12,
      OP_MUL   = 4'd13,
      OP_DIV   = 4'd14,
      OP_MOD   = 4'd15
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } md_state_t;

endpackage

// File: rtl/alu_exec_unit_rv32i_if.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_rv32i_if
// Operand/result bus of the EX-stage ALU.
//   master : upstream operand mux + downstream EX/MEM register (drives ops,
//            operands and out_ready; observes ready/valid/result/busy)
//   slave  : the execution unit
// ---------------------------------------------------------------------------
interface alu_exec_unit_rv32i_if
   import alu_pkg::*;
   #(parameter int XLEN = XLEN_DEFAULT) ();

   logic            in_valid;
   logic            in_ready;
   alu_op_t         ALU_op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   modport master (
      output in_valid, ALU_op, a, b, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, ALU_op, a, b, out_ready,
      output in_ready, out_valid, result, busy
   );

endinterface

// File: rtl/alu_exec_unit_rv32i_muldiv.sv
// ---------------------------------------------------------------------------
// muldiv_iter_rv32i
// Iterative signed multiply (shift-add) and signed divide/remainder
// (restoring division on magnitudes, then a sign-fix cycle).
//   clk, rst     : clock, synchronous active-high reset
//   start_mul_i  : begin a multiply with a_i * b_i (only honoured when idle)
//   start_div_i  : begin a divide/remainder of a_i by b_i
//   is_mod_i     : with start_div_i, selects remainder instead of quotient
//   idle_o       : sequencer is idle and can start a new op
//   done_o       : one-cycle pulse, result_o is valid this cycle
//   result_o     : final product/quotient/remainder
// ---------------------------------------------------------------------------
module muldiv_iter_rv32i
   import alu_pkg::*;
   #(parameter int XLEN = XLEN_DEFAULT)
   (
      input  logic            clk,
      input  logic            rst,
      input  logic            start_mul_i,
      input  logic            start_div_i,
      input  logic            is_mod_i,
      input  logic [XLEN-1:0] a_i,
      input  logic [XLEN-1:0] b_i,
      output logic            idle_o,
      output logic            done_o,
      output logic [XLEN-1:0] result_o
   );

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   // acc: product (MUL) or partial remainder (DIV)
   // op1: shifting multiplicand (MUL) or dividend/quotient shift reg (DIV)
   // op2: shifting multiplier (MUL) or divisor magnitude (DIV)
   md_state_t       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0] op1_q, op1_d;
   logic [XLEN-1:0] op2_q, op2_d;
   logic            quo_neg_q, quo_neg_d;
   logic            rem_neg_q, rem_neg_d;
   logic            mod_q, mod_d;

   logic [XLEN-1:0] mul_sum;
   logic [XLEN:0]   div_shift;
   logic [XLEN:0]   div_diff;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;

   assign idle_o = (state_q == IDLE);

   // Sequencer: one shift-add or one restoring step per cycle.  A negative
   // div_diff (top bit set) means the trial subtraction failed, so the
   // remainder is restored and a 0 quotient bit shifts in.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      quo_neg_d = quo_neg_q;
      rem_neg_d = rem_neg_q;
      mod_d     = mod_q;
      done_o    = 1'b0;
      result_o  = '0;

      mul_sum   = acc_q + (op2_q[0] ? op1_q : '0);
      div_shift = {acc_q, op1_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, op2_q};
      a_mag     = a_i[XLEN-1] ? (XLEN'(0) - a_i) : a_i;
      b_mag     = b_i[XLEN-1] ? (XLEN'(0) - b_i) : b_i;

      case (state_q)
         IDLE: begin
            if (start_mul_i) begin
               state_d   = MUL;
               cnt_d     = '0;
               acc_d     = '0;
               op1_d     = a_i;
               op2_d     = b_i;
               quo_neg_d = 1'b0;
               rem_neg_d = 1'b0;
               mod_d     = 1'b0;
            end else if (start_div_i) begin
               state_d   = DIV;
               cnt_d     = '0;
               acc_d     = '0;
               op1_d     = a_mag;
               op2_d     = b_mag;
               quo_neg_d = a_i[XLEN-1] ^ b_i[XLEN-1];
               rem_neg_d = a_i[XLEN-1];
               mod_d     = is_mod_i;
            end
         end
         MUL: begin
            acc_d = mul_sum;
            op1_d = op1_q << 1;
            op2_d = op2_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               done_o   = 1'b1;
               result_o = mul_sum;
               state_d  = IDLE;
               cnt_d    = '0;
            end
         end
         DIV: begin
            acc_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            op1_d = {op1_q[XLEN-2:0], ~div_diff[XLEN]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = FIX;
               cnt_d   = '0;
            end
         end
         FIX: begin
            done_o = 1'b1;
            if (mod_q) begin
               result_o = rem_neg_q ? (XLEN'(0) - acc_q) : acc_q;
            end else begin
               result_o = quo_neg_q ? (XLEN'(0) - op1_q) : op1_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer registers; reset aborts any op in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         op1_q     <= '0;
         op2_q     <= '0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         mod_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         quo_neg_q <= quo_neg_d;
         rem_neg_q <= rem_neg_d;
         mod_q     <= mod_d;
      end
   end

endmodule

// File: rtl/alu_exec_unit_rv32i.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_rv32i
// EX-stage integer unit: single-cycle RV32I ALU ops plus iterative signed
// mul/div/mod, with a valid/ready handshake and a registered result.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of alu_exec_unit_rv32i_if
//              in_valid/in_ready/ALU_op/a/b     : operation input
//              out_valid/out_ready/result       : registered result output
//              busy                             : iterative op in progress
// ---------------------------------------------------------------------------
module alu_exec_unit_rv32i
   import alu_pkg::*;
   #(parameter int XLEN = XLEN_DEFAULT)
   (
      input  logic                  clk,
      input  logic                  rst,
      alu_exec_unit_rv32i_if.slave  bus
   );

   localparam int SHW = $clog2(XLEN);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_res;
   logic            div_short;
   logic            op_is_div;
   logic            single_cycle;
   logic            accept;
   logic            start_mul;
   logic            start_div;
   logic            md_idle;
   logic            md_done;
   logic [XLEN-1:0] md_result;

   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] result_q, result_d;

   assign shamt = bus.b[SHW-1:0];

   // Single-cycle ALU.  Divide-by-zero and INT_MIN/-1 are resolved here so
   // they never enter the iterative divider.
   always_comb begin
      alu_res   = '0;
      div_short = 1'b0;
      case (bus.ALU_op)
         OP_ADD:   alu_res = bus.a + bus.b;
         OP_SUB:   alu_res = bus.a - bus.b;
         OP_XOR:   alu_res = bus.a ^ bus.b;
         OP_OR:    alu_res = bus.a | bus.b;
         OP_AND:   alu_res = bus.a & bus.b;
         OP_SLL:   alu_res = bus.a << shamt;
         OP_SRL:   alu_res = bus.a >> shamt;
         OP_SRA:   alu_res = $signed(bus.a) >>> shamt;
         OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
         OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
         OP_PASSB: alu_res = bus.b;
         OP_ABS:   alu_res = bus.a[XLEN-1] ? (XLEN'(0) - bus.a) : bus.a;
         OP_DIV, OP_MOD: begin
            if (bus.b == '0) begin
               div_short = 1'b1;
               alu_res   = (bus.ALU_op == OP_DIV) ? '1 : bus.a;
            end else if ((bus.a == INT_MIN) && (bus.b == '1)) begin
               div_short = 1'b1;
               alu_res   = (bus.ALU_op == OP_DIV) ? INT_MIN : '0;
            end
         end
         default:  alu_res = '0;
      endcase
   end

   assign op_is_div    = (bus.ALU_op == OP_DIV) || (bus.ALU_op == OP_MOD);
   assign single_cycle = (bus.ALU_op != OP_MUL) && !(op_is_div && !div_short);
   assign bus.in_ready = md_idle && (!out_valid_q || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign start_mul    = accept && (bus.ALU_op == OP_MUL);
   assign start_div    = accept && op_is_div && !div_short;

   muldiv_iter_rv32i #(.XLEN(XLEN)) u_muldiv (
      .clk         (clk),
      .rst         (rst),
      .start_mul_i (start_mul),
      .start_div_i (start_div),
      .is_mod_i    (bus.ALU_op == OP_MOD),
      .a_i         (bus.a),
      .b_i         (bus.b),
      .idle_o      (md_idle),
      .done_o      (md_done),
      .result_o    (md_result)
   );

   // Output slot: holds until consumed; a new result may load in the same
   // cycle the old one is taken.
   always_comb begin
      result_d    = result_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      if (accept && single_cycle) begin
         result_d    = alu_res;
         out_valid_d = 1'b1;
      end else if (md_done) begin
         result_d    = md_result;
         out_valid_d = 1'b1;
      end
   end

   // Result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.busy      = !md_idle;

endmodule

// File: tb/tb_alu_exec_unit_rv32i.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit_rv32i
// Scoreboard bench for alu_exec_unit_rv32i: the driver pushes the expected
// result and arrival cycle when an op is accepted; a monitor pops and
// compares whenever a new result appears on the output.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit_rv32i;
   import alu_pkg::*;

   localparam int XLEN = 32;

   typedef struct {
      logic [31:0] res;
      int          due;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   bit   rand_ready = 1'b0;
   exp_t sb_q[$];

   alu_exec_unit_rv32i_if #(.XLEN(XLEN)) bus();

   alu_exec_unit_rv32i #(.XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Hard time limit so the bench can never hang.
   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_fail);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   // Reference model written straight from the arithmetic rules.
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output int lat);
      int     sa;
      int     sb;
      longint p;
      sa  = a;
      sb  = b;
      lat = 1;
      r   = '0;
      case (op)
         4'd0:  r = a + b;
         4'd1:  r = a - b;
         4'd2:  r = a ^ b;
         4'd3:  r = a | b;
         4'd4:  r = a & b;
         4'd5:  r = a << b[4:0];
         4'd6:  r = a >> b[4:0];
         4'd7:  r = sa >>> b[4:0];
         4'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
         4'd9:  r = (a < b) ? 32'd1 : 32'd0;
         4'd11: r = b;
         4'd12: r = (sa < 0) ? -sa : sa;
         4'd13: begin
            p   = longint'(sa) * longint'(sb);
            r   = p[31:0];
            lat = 33;
         end
         4'd14: begin
            if (b == 32'd0) r = 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
            else begin
               r   = sa / sb;
               lat = 34;
            end
         end
         4'd15: begin
            if (b == 32'd0) r = a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
            else begin
               r   = sa % sb;
               lat = 34;
            end
         end
         default: r = 32'd0;
      endcase
   endfunction

   // Present one op, wait (bounded) for acceptance, record the expectation.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_res, input int lat, input string name,
                                output int waits);
      exp_t e;
      bus.ALU_op   = alu_op_t'(op);
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      waits        = 0;
      #1;
      while (!bus.in_ready && waits < 200) begin
         @(negedge clk);
         #1;
         waits++;
      end
      if (!bus.in_ready) begin
         n_cmp++;
         n_fail++;
         $display("[TB] FAIL %s accept: in_ready never rose, waited %0d cycles, required <200", name, waits);
         bus.in_valid = 1'b0;
         return;
      end
      e.res  = exp_res;
      e.due  = cyc + lat;
      e.name = name;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic runDir(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int lat, input string name);
      int w;
      applyStimulus(op, a, b, exp_res, lat, name, w);
   endtask

   // Entered at a falling edge; checks the unit stays busy for n cycles.
   task automatic checkBusy(input int n, input string name);
      for (int i = 0; i < n; i++) begin
         #1;
         checkOutput({name, " busy"}, 32'(bus.busy), 32'd1);
         checkOutput({name, " in_ready"}, 32'(bus.in_ready), 32'd0);
         @(negedge clk);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 7)
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         5: return $urandom % 64;
         default: return $urandom;
      endcase
   endfunction

   // Random consumer backpressure during the random phase.
   initial begin
      forever begin
         @(negedge clk);
         if (rand_ready) bus.out_ready = (($urandom % 4) != 0);
      end
   end

   // Monitor: a result is new when the previous cycle was not holding one.
   initial begin
      exp_t cur;
      bit   holding;
      holding = 1'b0;
      cur.res = '0;
      cur.due = 0;
      cur.name = "none";
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            holding = 1'b0;
         end else if (bus.out_valid) begin
            if (!holding) begin
               if (sb_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("[TB] FAIL unexpected result: got 0x%08h, required no output", bus.result);
               end else begin
                  cur = sb_q.pop_front();
                  checkOutput(cur.name, bus.result, cur.res);
                  checkOutput({cur.name, " arrival cycle"}, 32'(cyc), 32'(cur.due));
               end
            end else begin
               checkOutput({cur.name, " hold"}, bus.result, cur.res);
            end
            holding = !bus.out_ready;
         end else begin
            if (holding) begin
               n_cmp++;
               n_fail++;
               $display("[TB] FAIL %s dropped: out_valid 0 while stalled, required 1", cur.name);
            end
            holding = 1'b0;
         end
      end
   end

   initial begin
      int          w;
      logic [3:0]  op;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] rr;
      int          lat;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.ALU_op    = OP_ADD;
      bus.a         = '0;
      bus.b         = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("reset result", bus.result, 32'd0);
      checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);

      $display("[TB] directed single-cycle ops");
      runDir(4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, "add overflow");
      runDir(4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1, "sub 0-1");
      runDir(4'd2,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1, "xor");
      runDir(4'd3,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1, "or");
      runDir(4'd4,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1, "and");
      runDir(4'd5,  32'h00000001, 32'h0000003F, 32'h80000000, 1, "sll shamt low bits");
      runDir(4'd6,  32'h80000000, 32'h0000001F, 32'h00000001, 1, "srl 31");
      runDir(4'd7,  32'h80000000, 32'h00000004, 32'hF8000000, 1, "sra sign fill");
      runDir(4'd9,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1, "sltu");
      runDir(4'd8,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1, "slt");
      runDir(4'd10, 32'h00000123, 32'h00000456, 32'h00000000, 1, "reserved op");
      runDir(4'd11, 32'hDEADBEEF, 32'h12345000, 32'h12345000, 1, "pass b");
      runDir(4'd12, 32'hFFFFFFFB, 32'h00000000, 32'h00000005, 1, "abs -5");
      runDir(4'd12, 32'h80000000, 32'h00000000, 32'h80000000, 1, "abs int_min");

      $display("[TB] directed mul/div");
      runDir(4'd13, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 33, "mul -3*7");
      checkBusy(32, "mul");
      runDir(4'd14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34, "div -7/2");
      runDir(4'd15, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34, "mod -7%2");
      runDir(4'd14, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 34, "div 7/-2");
      runDir(4'd15, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 34, "mod 7%-2");
      runDir(4'd14, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1, "div by zero");
      runDir(4'd15, 32'h00000005, 32'h00000000, 32'h00000005, 1, "mod by zero");
      runDir(4'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div overflow");
      runDir(4'd15, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, "mod overflow");
      repeat (40) @(negedge clk);

      $display("[TB] backpressure");
      bus.out_ready = 1'b0;
      runDir(4'd13, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 33, "mul stalled");
      checkBusy(32, "mul stalled");
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput("stall in_ready", 32'(bus.in_ready), 32'd0);
         checkOutput("stall out_valid", 32'(bus.out_valid), 32'd1);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      applyStimulus(4'd0, 32'd2, 32'd3, 32'd5, 1, "add after release", w);
      checkOutput("same-cycle accept waits", 32'(w), 32'd0);
      @(negedge clk);

      $display("[TB] reset during divide");
      runDir(4'd14, 32'd100, 32'd7, 32'd14, 34, "div aborted");
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(sb_q.pop_back());
      #1;
      checkOutput("abort busy", 32'(bus.busy), 32'd0);
      checkOutput("abort out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("abort in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      runDir(4'd0, 32'd10, 32'd20, 32'd30, 1, "add after abort");

      $display("[TB] random ops");
      rand_ready = 1'b1;
      for (int i = 0; i < 150; i++) begin
         op = 4'($urandom % 16);
         ra = pick();
         rb = pick();
         model(op, ra, rb, rr, lat);
         applyStimulus(op, ra, rb, rr, lat, $sformatf("rand%0d op%0d", i, op), w);
      end
      @(negedge clk);
      rand_ready    = 1'b0;
      bus.out_ready = 1'b1;

      for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("[TB] FAIL drain: %0d results outstanding, required 0", sb_q.size());
      end
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
